fft_seq_ctrl: RTL and testbench

- Sequencer for the 8-point FFT datapath (s_p -> mux -> butterfly -> demux -> reg1 feedback / p_s).
- Accepts a frame from s_p and steps the shared butterfly through STAGES x BEATS issue cycles.
- Drives the mux select, butterfly twiddle/rotation code and demux select, then hands the final stage to p_s with a load pulse.
- Handles inter-stage feedback spacing and back-pressure from p_s.

---
 rtl/fft_seq_ctrl_if.sv | 27 ++
 rtl/fft_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_seq_ctrl_if.sv
// Handshake and control bundle between the FFT sequencer and its datapath neighbours.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface fft_seq_ctrl_if;
  localparam int unsigned ROT_W = 3;
  localparam int unsigned CNT_W = 8;

  logic             s_p_flag_in;
  logic             p_s_ready;
  logic             s_p_ack;
  logic             mux_flag;
  logic             demux_flag;
  logic [ROT_W-1:0] rotation;
  logic             bf_en;
  logic             p_s_flag;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  modport slave (
    input  s_p_flag_in, p_s_ready,
    output s_p_ack, mux_flag, demux_flag, rotation, bf_en, p_s_flag, busy, frame_cnt
  );

  modport master (
    output s_p_flag_in, p_s_ready,
    input  s_p_ack, mux_flag, demux_flag, rotation, bf_en, p_s_flag, busy, frame_cnt
  );
endinterface

// File: rtl/fft_seq_ctrl.sv
// Sequencer for the 8-point FFT datapath: accepts a frame from s_p, steps the shared
// butterfly through STAGES x BEATS issue cycles, then hands the last stage to p_s.
module fft_seq_ctrl #(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned STAGE_GAP = 2,
  parameter int unsigned BF_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  fft_seq_ctrl_if.slave bus
);

  localparam int unsigned STAGE_W = 2;
  localparam int unsigned BEAT_W  = 3;
  localparam int unsigned GAP_W   = 3;
  localparam int unsigned ROT_W   = 3;
  localparam int unsigned CNT_W   = 8;

  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [GAP_W-1:0]   LAST_GAP   = GAP_W'(STAGE_GAP - 1);
  localparam logic [GAP_W-1:0]   LAST_DRAIN = GAP_W'(BF_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_e;

  state_e             state_q,      state_d;
  logic [STAGE_W-1:0] stage_q,      stage_d;
  logic [BEAT_W-1:0]  beat_q,       beat_d;
  logic [GAP_W-1:0]   gap_q,        gap_d;
  logic [ROT_W-1:0]   rotation_q,   rotation_d;
  logic [CNT_W-1:0]   frame_cnt_q,  frame_cnt_d;
  logic               mux_flag_q,   mux_flag_d;
  logic               demux_flag_q, demux_flag_d;
  logic               bf_en_q,      bf_en_d;
  logic               p_s_flag_q,   p_s_flag_d;
  logic               busy_q,       busy_d;
  logic               accept;

  assign accept = (state_q == IDLE) & bus.s_p_flag_in & bus.p_s_ready;

  // State register plus registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stage_q      <= '0;
      beat_q       <= '0;
      gap_q        <= '0;
      rotation_q   <= '0;
      frame_cnt_q  <= '0;
      mux_flag_q   <= 1'b0;
      demux_flag_q <= 1'b0;
      bf_en_q      <= 1'b0;
      p_s_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      rotation_q   <= rotation_d;
      frame_cnt_q  <= frame_cnt_d;
      mux_flag_q   <= mux_flag_d;
      demux_flag_q <= demux_flag_d;
      bf_en_q      <= bf_en_d;
      p_s_flag_q   <= p_s_flag_d;
      busy_q       <= busy_d;
    end
  end

  // Next state and counters; gap_q doubles as the stage-gap and drain counter.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = CALC;
          stage_d = '0;
          beat_d  = '0;
        end
      end
      CALC: begin
        if (beat_q == LAST_BEAT) begin
          gap_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = DRAIN;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            beat_d  = '0;
            state_d = (STAGE_GAP == 0) ? CALC : WAIT;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      WAIT: begin
        if (gap_q == LAST_GAP) begin
          state_d = CALC;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      DRAIN: begin
        if (gap_q == LAST_DRAIN) begin
          state_d = OUT;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      OUT: begin
        state_d     = IDLE;
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state, so registered outputs line up with it.
  always_comb begin
    bf_en_d      = (state_d == CALC);
    busy_d       = (state_d != IDLE);
    p_s_flag_d   = (state_d == OUT);
    mux_flag_d   = ((state_d == CALC) && (stage_d != '0)) || (state_d == WAIT);
    demux_flag_d = ((state_d == CALC) && (stage_d == LAST_STAGE)) ||
                   (state_d == DRAIN) || (state_d == OUT);
    rotation_d   = rotation_q;
    if (state_d == CALC) begin
      rotation_d = ROT_W'(32'(stage_d) * BEATS + 32'(beat_d));
    end else if (state_d == IDLE) begin
      rotation_d = '0;
    end
  end

  assign bus.s_p_ack    = accept;
  assign bus.mux_flag   = mux_flag_q;
  assign bus.demux_flag = demux_flag_q;
  assign bus.rotation   = rotation_q;
  assign bus.bf_en      = bf_en_q;
  assign bus.p_s_flag   = p_s_flag_q;
  assign bus.busy       = busy_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: default build plus a STAGE_GAP=0/BF_LAT=3 build,
// both compared cycle by cycle against a frame schedule built from the stage/beat rules.
module tb_fft_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_seq_ctrl_if if0 ();
  fft_seq_ctrl_if if1 ();

  fft_seq_ctrl #(.STAGES(3), .BEATS(2), .STAGE_GAP(2), .BF_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  fft_seq_ctrl #(.STAGES(3), .BEATS(2), .STAGE_GAP(0), .BF_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  int errors = 0;
  int checks = 0;
  int fc_exp [2];

  // Observed vector: {ack, busy, p_s_flag, bf_en, mux_flag, demux_flag, rotation[2:0]}
  localparam logic [8:0] M_ALL  = 9'h1FF;
  localparam logic [8:0] M_CTRL = 9'h1E8;
  logic [8:0] sq_e[$];
  logic [8:0] sq_m[$];

  // Expected per-cycle outputs of one frame, cycles T+1 .. T+N after the ack.
  task automatic build_sched(input int gap, input int lat);
    int rot;
    sq_e.delete();
    sq_m.delete();
    rot = 0;
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 2; b++) begin
        rot = s * 2 + b;
        sq_e.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'(s != 0), 1'(s == 2), 3'(rot)});
        sq_m.push_back(M_ALL);
      end
      if (s < 2) begin
        for (int g = 0; g < gap; g++) begin
          sq_e.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'(rot)});
          sq_m.push_back(M_ALL);
        end
      end
    end
    for (int d = 0; d < lat; d++) begin
      sq_e.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000});
      sq_m.push_back(M_CTRL);
    end
    sq_e.push_back({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000});
    sq_m.push_back(M_CTRL);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic f, input logic r);
    if (sel == 0) begin
      if0.s_p_flag_in = f;
      if0.p_s_ready   = r;
    end else begin
      if1.s_p_flag_in = f;
      if1.p_s_ready   = r;
    end
  endtask

  task automatic sample(input int sel, output logic [8:0] v, output logic [7:0] fc);
    if (sel == 0) begin
      v  = {if0.s_p_ack, if0.busy, if0.p_s_flag, if0.bf_en, if0.mux_flag, if0.demux_flag, if0.rotation};
      fc = if0.frame_cnt;
    end else begin
      v  = {if1.s_p_ack, if1.busy, if1.p_s_flag, if1.bf_en, if1.mux_flag, if1.demux_flag, if1.rotation};
      fc = if1.frame_cnt;
    end
  endtask

  task automatic test_reset();
    logic [8:0] v;
    logic [7:0] fc;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1);
    drive(1, 1'b0, 1'b0);
    #1;
    sample(0, v, fc);
    checks++;
    if (v !== 9'h100 || fc !== 8'd0) begin
      errors++;
      $display("FAIL reset_ack got=%b cnt=%0d want=%b cnt=0", v, fc, 9'h100);
    end
    sample(1, v, fc);
    checks++;
    if (v !== 9'h000 || fc !== 8'd0) begin
      errors++;
      $display("FAIL reset_sweep got=%b cnt=%0d want=000000000 cnt=0", v, fc);
    end
    drive(0, 1'b0, 1'b0);
    #1;
    sample(0, v, fc);
    checks++;
    if (v !== 9'h000) begin
      errors++;
      $display("FAIL reset_idle got=%b want=000000000", v);
    end
    step();
    step();
    rst_n = 1'b1;
    fc_exp[0] = 0;
    fc_exp[1] = 0;
  endtask

  task automatic test_idle();
    logic [8:0] v;
    logic [7:0] fc;
    for (int i = 0; i < 16; i++) begin
      step();
      drive(0, 1'b0, 1'($urandom_range(0, 1)));
      #1;
      sample(0, v, fc);
      checks++;
      if (v !== 9'h000 || fc !== 8'(fc_exp[0])) begin
        errors++;
        $display("FAIL idle cyc=%0d got=%b cnt=%0d want=000000000 cnt=%0d", i, v, fc, fc_exp[0]);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [8:0] v;
    logic [7:0] fc;
    build_sched(2, 1);
    step();
    drive(0, 1'b1, 1'b1);
    #1;
    sample(0, v, fc);
    checks++;
    if (v[8] !== 1'b1 || v[7] !== 1'b0) begin
      errors++;
      $display("FAIL single_ack got ack=%b busy=%b want ack=1 busy=0", v[8], v[7]);
    end
    for (int k = 0; k < sq_e.size(); k++) begin
      step();
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      sample(0, v, fc);
      checks++;
      if ((v & sq_m[k]) !== (sq_e[k] & sq_m[k])) begin
        errors++;
        $display("FAIL single T+%0d got=%b want=%b mask=%b", k + 1, v, sq_e[k], sq_m[k]);
      end
    end
    step();
    drive(0, 1'b0, 1'b0);
    #1;
    fc_exp[0] = (fc_exp[0] + 1) % 256;
    sample(0, v, fc);
    checks++;
    if ((v & M_CTRL) !== 9'h000 || fc !== 8'(fc_exp[0])) begin
      errors++;
      $display("FAIL single_done got=%b cnt=%0d want ctrl=0 cnt=%0d", v, fc, fc_exp[0]);
    end
  endtask

  task automatic test_back_pressure();
    logic [8:0] v;
    logic [7:0] fc;
    int n;
    build_sched(2, 1);
    for (int r = 0; r < 4; r++) begin
      n = (r == 0) ? 5 : int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) begin
        step();
        drive(0, 1'b1, 1'b0);
        #1;
        sample(0, v, fc);
        checks++;
        if (v[8] !== 1'b0 || v[7] !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold r=%0d cyc=%0d got ack=%b busy=%b want 0 0", r, i, v[8], v[7]);
        end
      end
      step();
      drive(0, 1'b1, 1'b1);
      #1;
      sample(0, v, fc);
      checks++;
      if (v[8] !== 1'b1) begin
        errors++;
        $display("FAIL bp_ack r=%0d got=%b want=1", r, v[8]);
      end
      for (int k = 0; k < sq_e.size(); k++) begin
        step();
        drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        #1;
        sample(0, v, fc);
        checks++;
        if ((v & sq_m[k]) !== (sq_e[k] & sq_m[k])) begin
          errors++;
          $display("FAIL bp r=%0d T+%0d got=%b want=%b mask=%b", r, k + 1, v, sq_e[k], sq_m[k]);
        end
      end
      step();
      drive(0, 1'b0, 1'b0);
      #1;
      fc_exp[0] = (fc_exp[0] + 1) % 256;
      sample(0, v, fc);
      checks++;
      if (fc !== 8'(fc_exp[0])) begin
        errors++;
        $display("FAIL bp_cnt r=%0d got=%0d want=%0d", r, fc, fc_exp[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] v;
    logic [7:0] fc;
    build_sched(2, 1);
    step();
    drive(0, 1'b1, 1'b1);
    #1;
    sample(0, v, fc);
    checks++;
    if (v[8] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_ack got=%b want=1", v[8]);
    end
    for (int k = 0; k < 6; k++) begin
      step();
      #1;
      sample(0, v, fc);
      checks++;
      if ((v & sq_m[k]) !== (sq_e[k] & sq_m[k])) begin
        errors++;
        $display("FAIL rmid_pre T+%0d got=%b want=%b", k + 1, v, sq_e[k]);
      end
    end
    rst_n = 1'b0;
    #1;
    sample(0, v, fc);
    checks++;
    if (v !== 9'h100 || fc !== 8'd0) begin
      errors++;
      $display("FAIL rmid_reset got=%b cnt=%0d want=%b cnt=0", v, fc, 9'h100);
    end
    fc_exp[0] = 0;
    fc_exp[1] = 0;
    step();
    rst_n = 1'b1;
    #1;
    sample(0, v, fc);
    checks++;
    if (v[8] !== 1'b1 || v[7] !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reack got ack=%b busy=%b want 1 0", v[8], v[7]);
    end
    for (int k = 0; k < sq_e.size(); k++) begin
      step();
      drive(0, 1'b1, 1'($urandom_range(0, 1)));
      #1;
      sample(0, v, fc);
      checks++;
      if ((v & sq_m[k]) !== (sq_e[k] & sq_m[k])) begin
        errors++;
        $display("FAIL rmid T+%0d got=%b want=%b mask=%b", k + 1, v, sq_e[k], sq_m[k]);
      end
    end
    step();
    drive(0, 1'b0, 1'b0);
    #1;
    fc_exp[0] = (fc_exp[0] + 1) % 256;
    sample(0, v, fc);
    checks++;
    if (fc !== 8'(fc_exp[0])) begin
      errors++;
      $display("FAIL rmid_cnt got=%0d want=%0d", fc, fc_exp[0]);
    end
  endtask

  task automatic test_sweep();
    logic [8:0] v;
    logic [7:0] fc;
    build_sched(0, 3);
    step();
    drive(1, 1'b1, 1'b1);
    #1;
    sample(1, v, fc);
    checks++;
    if (v[8] !== 1'b1) begin
      errors++;
      $display("FAIL sweep_ack got=%b want=1", v[8]);
    end
    for (int k = 0; k < sq_e.size(); k++) begin
      step();
      drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      sample(1, v, fc);
      checks++;
      if ((v & sq_m[k]) !== (sq_e[k] & sq_m[k])) begin
        errors++;
        $display("FAIL sweep T+%0d got=%b want=%b mask=%b", k + 1, v, sq_e[k], sq_m[k]);
      end
    end
    step();
    drive(1, 1'b0, 1'b0);
    #1;
    fc_exp[1] = (fc_exp[1] + 1) % 256;
    sample(1, v, fc);
    checks++;
    if ((v & M_CTRL) !== 9'h000 || fc !== 8'(fc_exp[1])) begin
      errors++;
      $display("FAIL sweep_done got=%b cnt=%0d want ctrl=0 cnt=%0d", v, fc, fc_exp[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] v;
    logic [7:0] fc;
    build_sched(2, 1);
    step();
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    fc_exp[0] = 0;
    fc_exp[1] = 0;
    step();
    drive(0, 1'b1, 1'b1);
    #1;
    for (int f = 0; f < 256; f++) begin
      sample(0, v, fc);
      checks++;
      if (v[8] !== 1'b1 || v[7] !== 1'b0 || fc !== 8'(fc_exp[0])) begin
        errors++;
        $display("FAIL b2b_ack f=%0d got ack=%b busy=%b cnt=%0d want 1 0 %0d", f, v[8], v[7], fc, fc_exp[0]);
      end
      for (int k = 0; k < sq_e.size(); k++) begin
        step();
        #1;
        sample(0, v, fc);
        checks++;
        if ((v & sq_m[k]) !== (sq_e[k] & sq_m[k])) begin
          errors++;
          $display("FAIL b2b f=%0d T+%0d got=%b want=%b mask=%b", f, k + 1, v, sq_e[k], sq_m[k]);
        end
      end
      step();
      #1;
      fc_exp[0] = (fc_exp[0] + 1) % 256;
    end
    drive(0, 1'b0, 1'b0);
    #1;
    sample(0, v, fc);
    checks++;
    if (fc !== 8'd0 || v !== 9'h000) begin
      errors++;
      $display("FAIL b2b_wrap got=%b cnt=%0d want=000000000 cnt=0", v, fc);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_frame();
    test_back_pressure();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
